// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch-stage PC sequencer
//
// Purpose: fetch FSM state encoding plus PC defaults/step used by fetch_ctrl.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    MISS       = 2'd2,
    MISS_FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-to-I-cache lookup/refill bus
//
// Purpose: bundles the fetch stage's I-cache lookup request and the cache's
//          hit/refill responses.
// Signals: ic_req (lookup request), ic_addr (lookup address),
//          ic_hit (same-cycle hit), ic_refill_done (one-cycle refill pulse).
// Modports: master = fetch side, slave = I-cache side.
interface fetch_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             ic_req;
  logic [WIDTH-1:0] ic_addr;
  logic             ic_hit;
  logic             ic_refill_done;

  modport master (
    output ic_req,
    output ic_addr,
    input  ic_hit,
    input  ic_refill_done
  );

  modport slave (
    input  ic_req,
    input  ic_addr,
    output ic_hit,
    output ic_refill_done
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose: counts cycles with inc high, sticking at all-ones instead of wrapping.
// Ports:   clk, rst (async active-high), inc (count enable), count (value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer against the instruction cache
//
// Purpose: holds the fetch PC across I-cache misses, stalls and flushes, applies
//          execute-stage redirects and counts miss cycles.
// Ports:   clk, rst (async active-high)
//          stall_f            hazard-unit hold
//          redirect/_pc       execute-stage taken branch/jump and its target
//          ic (master)        I-cache lookup request/address, hit, refill pulse
//          pc_f, pc_plus4_f   registered fetch PC and its wrapping successor
//          instr_valid_f      fetched instruction valid this cycle
//          redirect_pending   redirect parked behind an un-abortable refill
//          miss_cnt           saturating count of MISS/MISS_FLUSH cycles
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              redirect,
  input  logic [WIDTH-1:0]  redirect_pc,
  fetch_ctrl_if.master      ic,
  output logic [WIDTH-1:0]  pc_f,
  output logic [WIDTH-1:0]  pc_plus4_f,
  output logic              instr_valid_f,
  output logic              redirect_pending,
  output logic [CNT_W-1:0]  miss_cnt
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pend_q, pend_d;
  logic             ic_req_q, ic_req_d;

  logic [WIDTH-1:0] redirect_tgt;
  logic [WIDTH-1:0] pc_plus4;

  // Instructions are word aligned; low target bits are discarded.
  assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
  assign pc_plus4     = pc_q + WIDTH'(PC_STEP);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end else if (ic.ic_hit) begin
          if (!stall_f) begin
            pc_d = pc_plus4;
          end
        end else begin
          state_d = MISS;
        end
      end

      MISS: begin
        if (redirect && ic.ic_refill_done) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (redirect) begin
          // Refill is still in flight; park the target until it lands.
          pend_pc_d = redirect_tgt;
          pend_d    = 1'b1;
          state_d   = MISS_FLUSH;
        end else if (ic.ic_refill_done) begin
          state_d = FETCH;
        end
      end

      MISS_FLUSH: begin
        if (redirect) begin
          pend_pc_d = redirect_tgt;
        end
        if (ic.ic_refill_done) begin
          // Youngest redirect wins, including one arriving with the refill.
          pc_d    = redirect ? redirect_tgt : pend_pc_q;
          pend_d  = 1'b0;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    // Lookup is requested in exactly the cycles the FSM sits in FETCH.
    ic_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      ic_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      ic_req_q  <= ic_req_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state_q == MISS) || (state_q == MISS_FLUSH)),
    .count (miss_cnt)
  );

  // Hit response is same-cycle, so validity cannot be registered.
  assign instr_valid_f    = (state_q == FETCH) && ic.ic_hit && !redirect;
  assign ic.ic_req        = ic_req_q;
  assign ic.ic_addr       = pc_q;
  assign pc_f             = pc_q;
  assign pc_plus4_f       = pc_plus4;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_f;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc_plus4_f;
  logic             instr_valid_f;
  logic             redirect_pending;
  logic [CNT_W-1:0] miss_cnt;

  fetch_ctrl_if #(.WIDTH(WIDTH)) ic_bus ();

  fetch_ctrl #(
    .WIDTH    (WIDTH),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_f          (stall_f),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .ic               (ic_bus.master),
    .pc_f             (pc_f),
    .pc_plus4_f       (pc_plus4_f),
    .instr_valid_f    (instr_valid_f),
    .redirect_pending (redirect_pending),
    .miss_cnt         (miss_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; queue the PC expected to be
  // presented as valid in that cycle.
  task automatic drive(input logic hit, input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic done,
                       input logic ev, input logic [31:0] epc);
    @(posedge clk);
    #1;
    ic_bus.ic_hit         = hit;
    stall_f               = stall;
    redirect              = redir;
    redirect_pc           = rpc;
    ic_bus.ic_refill_done = done;
    if (ev) exp_q.push_back(epc);
  endtask

  // Monitor: every valid fetch must match the next queued PC.
  always @(negedge clk) begin
    if (instr_valid_f) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid pc_f=%0h expected no valid fetch", pc_f);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("fetch_pc", pc_f, e);
        check("ic_addr", ic_bus.ic_addr, e);
      end
    end
  end

  initial begin
    rst                   = 1'b1;
    stall_f               = 1'b0;
    redirect              = 1'b0;
    redirect_pc           = '0;
    ic_bus.ic_hit         = 1'b0;
    ic_bus.ic_refill_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc_f, 32'h0);
    check("rst_ic_req", 32'(ic_bus.ic_req), 32'h0);
    check("rst_valid", 32'(instr_valid_f), 32'h0);
    check("rst_pending", 32'(redirect_pending), 32'h0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'h0);

    // Release reset: one BOOT cycle with no request.
    @(posedge clk);
    #1;
    rst           = 1'b0;
    ic_bus.ic_hit = 1'b1;
    @(negedge clk);
    check("boot_ic_req", 32'(ic_bus.ic_req), 32'h0);

    // Sequential hits.
    drive(1, 0, 0, 0, 0, 1, 32'h0);
    @(negedge clk);
    check("fetch_ic_req", 32'(ic_bus.ic_req), 32'h1);
    drive(1, 0, 0, 0, 0, 1, 32'h4);
    drive(1, 0, 0, 0, 0, 1, 32'h8);
    drive(1, 0, 0, 0, 0, 1, 32'hC);
    drive(0, 0, 0, 0, 0, 0, 0);             // miss at 0x10

    // Five miss cycles, refill on the fifth.
    drive(1, 0, 0, 0, 0, 0, 0);             // hit ignored in MISS
    @(negedge clk);
    check("miss_ic_req", 32'(ic_bus.ic_req), 32'h0);
    check("miss_pc_hold", pc_f, 32'h10);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h10);
    @(negedge clk);
    check("miss_cnt_5", 32'(miss_cnt), 32'd5);
    drive(1, 0, 0, 0, 0, 1, 32'h14);
    drive(1, 0, 0, 0, 0, 1, 32'h18);
    drive(1, 0, 0, 0, 0, 1, 32'h1C);
    drive(0, 0, 0, 0, 0, 0, 0);             // miss at 0x20

    // Redirect in the second miss cycle parks the target.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h103, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_pending_1", 32'(redirect_pending), 32'h1);
    check("flush_pc_hold", pc_f, 32'h20);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_pending_2", 32'(redirect_pending), 32'h1);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h100);
    @(negedge clk);
    check("flush_pending_clr", 32'(redirect_pending), 32'h0);
    check("miss_cnt_10", 32'(miss_cnt), 32'd10);

    // Youngest of two flush redirects wins.
    drive(0, 0, 0, 0, 0, 0, 0);             // miss at 0x104
    drive(0, 0, 1, 32'h200, 0, 0, 0);
    drive(0, 0, 1, 32'h300, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h300);
    @(negedge clk);
    check("miss_cnt_13", 32'(miss_cnt), 32'd13);

    // Redirect coinciding with refill in MISS.
    drive(0, 0, 0, 0, 0, 0, 0);             // miss at 0x304
    drive(0, 0, 1, 32'h403, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);             // at 0x400, miss again
    @(negedge clk);
    check("miss_redir_done_pc", pc_f, 32'h400);
    check("miss_redir_done_pend", 32'(redirect_pending), 32'h0);
    check("miss_cnt_14", 32'(miss_cnt), 32'd14);

    // Redirect coinciding with refill in MISS_FLUSH beats the parked one.
    drive(0, 0, 1, 32'h500, 0, 0, 0);
    drive(0, 0, 1, 32'h600, 1, 0, 0);
    drive(1, 0, 1, 32'h40, 0, 0, 0);        // redirect in FETCH at 0x600
    @(negedge clk);
    check("flush_redir_done_pc", pc_f, 32'h600);
    check("fetch_redir_valid", 32'(instr_valid_f), 32'h0);
    check("miss_cnt_sat", 32'(miss_cnt), 32'd15);

    // Stalled hits hold the PC; redirect while stalled wins.
    drive(1, 1, 0, 0, 0, 1, 32'h40);
    drive(1, 1, 0, 0, 0, 1, 32'h40);
    drive(1, 1, 0, 0, 0, 1, 32'h40);
    drive(1, 1, 1, 32'h80, 0, 0, 0);
    @(negedge clk);
    check("stall_redir_valid", 32'(instr_valid_f), 32'h0);
    check("stall_redir_pc", pc_f, 32'h40);
    drive(1, 0, 0, 0, 0, 1, 32'h80);
    drive(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);  // at 0x84
    drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_plus4", pc_plus4_f, 32'h0);
    drive(1, 0, 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);             // miss at 0x4
    drive(0, 0, 1, 32'h700, 0, 0, 0);

    // Asynchronous reset in the middle of MISS_FLUSH.
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc_f, 32'h0);
    check("arst_ic_req", 32'(ic_bus.ic_req), 32'h0);
    check("arst_valid", 32'(instr_valid_f), 32'h0);
    check("arst_pending", 32'(redirect_pending), 32'h0);
    check("arst_miss_cnt", 32'(miss_cnt), 32'h0);

    // BOOT ignores redirect and stray refill.
    @(posedge clk);
    #1;
    rst                   = 1'b0;
    ic_bus.ic_hit         = 1'b1;
    redirect              = 1'b1;
    redirect_pc           = 32'h900;
    ic_bus.ic_refill_done = 1'b1;
    drive(1, 0, 0, 0, 1, 1, 32'h0);
    drive(1, 0, 0, 0, 0, 1, 32'h4);
    @(negedge clk);
    check("post_rst_miss_cnt", 32'(miss_cnt), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
